// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 104;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BREAK = ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops reset to 1.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_char.sv
// 8N1 UART receiver: one character byte plus a one-cycle strobe per good frame.
//   state | meaning
//   IDLE  | line high, waiting for a start edge
//   START | confirm start bit at its midpoint
//   DATA  | sample 8 data bits, LSB first
//   STOP  | sample stop bit, emit char or framing error
//   BREAK | line held low after a bad stop bit; wait for it to rise
module uart_rx_char
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] charData,
  output logic       charDataValid,
  output logic       frameErr,
  output logic       rxBusy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [2:0]    IDX_LAST_C = 3'(UART_DATA_BITS - 1);

  logic rxs;

  rx_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    char_d  = char_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + ONE_C;
        // Counter restarts every bit so non-power-of-two bit periods work.
        if (cnt_q == LAST_C) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rxs;
          if (idx_q == IDX_LAST_C) state_d = S_STOP;
          else                     idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rxs) begin
            char_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign charData      = char_q;
  assign charDataValid = valid_q;
  assign frameErr      = ferr_q;
  assign rxBusy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_char.sv
// Randomized bench for uart_rx_char against a frame-level event model.
module tb_uart_rx_char;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
  // rxd fall -> strobe: 3 edges to reach START, then HALF+9*CPB+1 cycles.
  localparam int LAT  = 3 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] charData;
  logic       charDataValid;
  logic       frameErr;
  logic       rxBusy;

  typedef struct {
    bit          kind;   // 0 = char valid, 1 = frame error
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  model_char;
  logic [7:0]  prev_char = 8'h00;

  uart_rx_char #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .charData      (charData),
    .charDataValid (charDataValid),
    .frameErr      (frameErr),
    .rxBusy        (rxBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (charDataValid || frameErr)
        check_eq("strobe_exclusive", {31'd0, charDataValid & frameErr}, 32'd0);
      if (charDataValid) obs_q.push_back('{kind: 1'b0, data: charData, cyc: cyc});
      if (frameErr)      obs_q.push_back('{kind: 1'b1, data: charData, cyc: cyc});
      if (charData !== prev_char)
        check_eq("char_changes_only_on_valid", {31'd0, charDataValid}, 32'd1);
    end
    prev_char <= charData;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    int unsigned fall;
    ev_t e;
    fall = cyc;
    rxd  = 1'b0;
    for (int k = 1; k <= CPB; k++) begin
      tick();
      if (k == 2) check_eq("busy_before_start", {31'd0, rxBusy}, 32'd0);
      if (k == 3) check_eq("busy_at_start", {31'd0, rxBusy}, 32'd1);
    end
    e.kind = !stop;
    e.data = stop ? d : model_char;
    e.cyc  = fall + LAT;
    exp_q.push_back(e);
    if (stop) model_char = d;
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    hold(stop, CPB);
  endtask

  task automatic check_events();
    ev_t o;
    ev_t x;
    check_eq("event_count", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      check_eq("event_kind", {31'd0, o.kind}, {31'd0, x.kind});
      check_eq("event_char", {24'd0, o.data}, {24'd0, x.data});
      check_eq("event_cycle", o.cyc, x.cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    logic [7:0] d;
    logic       stop;

    model_char = 8'h00;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) tick();
    check_eq("rst_char", {24'd0, charData}, 32'h00);
    check_eq("rst_valid", {31'd0, charDataValid}, 32'd0);
    check_eq("rst_ferr", {31'd0, frameErr}, 32'd0);
    check_eq("rst_busy", {31'd0, rxBusy}, 32'd0);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // Single good frame
    send_frame(8'h1B, 1'b1);
    hold(1'b1, CPB);
    check_events();

    // Back-to-back frames, no idle gap
    send_frame(8'h53, 1'b1);
    send_frame(8'h35, 1'b1);
    hold(1'b1, CPB);
    if (obs_q.size() == 2)
      check_eq("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, 10 * CPB);
    check_events();

    // Short glitch on the idle line
    busy_cnt = 0;
    hold(1'b0, 2);
    rxd = 1'b1;
    for (int k = 0; k < 3 * CPB; k++) begin
      tick();
      if (rxBusy) busy_cnt++;
    end
    check_eq("glitch_busy_bounded", {31'd0, (busy_cnt > 0 && busy_cnt <= 4)}, 32'd1);
    check_eq("glitch_char", {24'd0, charData}, {24'd0, model_char});
    check_events();

    // Framing error followed by a held-low break, then recovery
    send_frame(8'h40, 1'b0);
    hold(1'b0, 40);
    check_eq("break_busy", {31'd0, rxBusy}, 32'd1);
    check_events();
    hold(1'b1, 2 * CPB);
    check_eq("break_exit_busy", {31'd0, rxBusy}, 32'd0);
    send_frame(8'h0D, 1'b1);
    hold(1'b1, CPB);
    check_events();

    // Reset in the middle of data bit 4
    d = 8'hA5;
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(d[4], CPB / 2);
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    check_eq("midrst_char", {24'd0, charData}, 32'h00);
    check_eq("midrst_valid", {31'd0, charDataValid}, 32'd0);
    check_eq("midrst_ferr", {31'd0, frameErr}, 32'd0);
    check_eq("midrst_busy", {31'd0, rxBusy}, 32'd0);
    model_char = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    hold(1'b1, 3 * CPB);
    check_events();
    send_frame(8'h61, 1'b1);
    hold(1'b1, CPB);
    check_events();

    // Random frames, random stop bits and gaps
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      check_events();
      if (!stop) begin
        hold(1'b0, $urandom_range(0, 3 * CPB));
        hold(1'b1, 2 * CPB + $urandom_range(0, CPB));
      end else begin
        hold(1'b1, $urandom_range(0, 2 * CPB));
      end
    end
    hold(1'b1, 2 * CPB);
    check_events();
    check_eq("final_char", {24'd0, charData}, {24'd0, model_char});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
